// File: rtl/rr_burst_arb.sv
// Round-robin / fixed-priority burst arbiter with per-requester beat quotas.
// One grant is presented at a time; bursts end back-to-back into the next winner.
module rr_burst_arb #(
   parameter int unsigned LG_N = 2,
   parameter int unsigned LG_Q = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [(1<<LG_N)-1:0]       req,
   input  logic                       mode,
   input  logic [(1<<LG_N)*LG_Q-1:0]  quota,
   input  logic                       gnt_ready,
   output logic                       gnt_valid,
   output logic [LG_N-1:0]            gnt_idx,
   output logic [(1<<LG_N)-1:0]       gnt_onehot,
   output logic                       gnt_last,
   output logic                       proto_err
);

   localparam int unsigned N = 1 << LG_N;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_nxt;
   logic [LG_N-1:0]   ptr, ptr_nxt;
   logic [LG_N-1:0]   arb_ptr, win, idx_nxt;
   logic [LG_Q-1:0]   cnt, cnt_nxt, win_q;
   logic [N-1:0]      onehot_nxt;
   logic              arb, hs, valid_nxt, last_nxt, err_nxt;

   // At burst end the scan starts just past the finishing requester (round-robin only).
   assign arb_ptr = (state == GRANT && !mode) ? gnt_idx + LG_N'(1) : ptr;

   // Winner: descending scan so the lowest offset from the start point wins.
   always_comb begin
      win = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (mode) begin
            if (req[i]) win = LG_N'(i);
         end else begin
            if (req[arb_ptr + LG_N'(i)]) win = arb_ptr + LG_N'(i);
         end
      end
   end

   assign win_q = quota[int'(win) * int'(LG_Q) +: LG_Q];

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      idx_nxt   = gnt_idx;
      arb       = 1'b0;
      hs        = gnt_valid & gnt_ready;

      case (state)
         IDLE: begin
            if (|req) arb = 1'b1;
         end
         GRANT: begin
            if (hs) begin
               if (gnt_last) begin
                  if (!mode) ptr_nxt = gnt_idx + LG_N'(1);
                  if (|req) begin
                     arb = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                  end
               end else begin
                  cnt_nxt = cnt - LG_Q'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A zero quota still grants a single beat.
      if (arb) begin
         state_nxt = GRANT;
         idx_nxt   = win;
         cnt_nxt   = (win_q == '0) ? LG_Q'(1) : win_q;
      end

      valid_nxt  = (state_nxt == GRANT);
      onehot_nxt = valid_nxt ? (N'(1) << idx_nxt) : '0;
      last_nxt   = valid_nxt && ((cnt_nxt == LG_Q'(1)) || !req[idx_nxt]);
      err_nxt    = proto_err | (gnt_valid & ~req[gnt_idx] & ~gnt_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         gnt_last   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         gnt_valid  <= valid_nxt;
         gnt_idx    <= idx_nxt;
         gnt_onehot <= onehot_nxt;
         gnt_last   <= last_nxt;
         proto_err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Bench for rr_burst_arb: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of grants and beat quotas.
module tb_rr_burst_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       mode;
   logic [7:0] quota;
   logic       gnt_ready;
   logic       gnt_valid;
   logic [1:0] gnt_idx;
   logic [3:0] gnt_onehot;
   logic       gnt_last;
   logic       proto_err;

   int vectors = 0;
   int errors  = 0;

   // Model: who holds the grant, how many beats remain, where the scan starts.
   int m_valid, m_idx, m_rem, m_ptr, m_last, m_err;

   rr_burst_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mode       (mode),
      .quota      (quota),
      .gnt_ready  (gnt_ready),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .gnt_last   (gnt_last),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int start, input logic fixed);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = fixed ? k : (start + k) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_idx = 0; m_rem = 0; m_ptr = 0; m_last = 0; m_err = 0;
   endtask

   task automatic model_grant();
      int w, qv;
      w = pick(req, m_ptr, mode);
      if (w < 0) begin
         m_valid = 0;
         m_rem   = 0;
      end else begin
         m_valid = 1;
         m_idx   = w;
         qv      = int'((quota >> (2 * w)) & 8'h3);
         m_rem   = (qv == 0) ? 1 : qv;
      end
   endtask

   task automatic model_edge();
      int new_err;
      if (!rst) begin
         model_reset();
         return;
      end
      new_err = (m_err != 0 || (m_valid != 0 && !req[m_idx] && !gnt_ready)) ? 1 : 0;
      if (m_valid != 0) begin
         if (gnt_ready) begin
            m_rem--;
            if (m_last != 0) begin
               if (!mode) m_ptr = (m_idx + 1) % 4;
               model_grant();
            end
         end
      end else if (req != 4'b0) begin
         model_grant();
      end
      m_last = (m_valid != 0 && (m_rem == 1 || !req[m_idx])) ? 1 : 0;
      m_err  = new_err;
   endtask

   task automatic compare_all();
      chk("valid", 32'(gnt_valid), 32'(m_valid));
      chk("onehot", 32'(gnt_onehot), (m_valid != 0) ? (32'd1 << m_idx) : 32'd0);
      chk("last", 32'(gnt_last), 32'(m_last));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      if (m_valid != 0) chk("idx", 32'(gnt_idx), 32'(m_idx));
   endtask

   // One clock: model and DUT both take the edge, then compare 1ns later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 32'(gnt_valid), 32'd0);
      chk("rst_onehot", 32'(gnt_onehot), 32'd0);
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; req = 4'b1111; mode = 1'b0; quota = 8'h55; gnt_ready = 1'b1;
      model_reset();
      #2;
      chk("por_idx", 32'(gnt_idx), 32'd0);
      chk("por_last", 32'(gnt_last), 32'd0);
      chk("por_err", 32'(proto_err), 32'd0);
      // No grant while reset is sampled low, even with requests pending.
      step();
      chk("no_grant_in_rst", 32'(gnt_valid), 32'd0);
      step();
      rst = 1'b1;

      // All requesting, quota 1: ascending wrapped order, every beat last.
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_seq_idx", 32'(gnt_idx), 32'(k % 4));
         chk("rr_seq_last", 32'(gnt_last), 32'd1);
      end

      // Sole requester with quota 3: three beats, last on third, then regrant.
      req = 4'b0100; quota = 8'h30;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("burst_idx", 32'(gnt_idx), 32'd2);
         chk("burst_last", 32'(gnt_last), (k == 2) ? 32'd1 : 32'd0);
      end

      // Stalled grant holds its index while other requests change.
      do_reset();
      req = 4'b0010; quota = 8'h55;
      step();
      chk("stall_first", 32'(gnt_idx), 32'd1);
      gnt_ready = 1'b0; req = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_idx", 32'(gnt_idx), 32'd1);
         chk("stall_onehot", 32'(gnt_onehot), 32'b0010);
      end
      gnt_ready = 1'b1;

      // Fixed priority: index 1 always beats index 3.
      do_reset();
      mode = 1'b1; req = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("fixed_idx", 32'(gnt_idx), 32'd1);
      end
      mode = 1'b0;

      // Withdrawal before acceptance raises a sticky error.
      do_reset();
      req = 4'b0001;
      step();
      chk("wd_grant", 32'(gnt_idx), 32'd0);
      req = 4'b0000; gnt_ready = 1'b0;
      step();
      chk("wd_err", 32'(proto_err), 32'd1);
      gnt_ready = 1'b1; req = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("wd_sticky", 32'(proto_err), 32'd1);
      end

      // Reset mid-burst of index 3 clears outputs at once; regrant after release.
      do_reset();
      req = 4'b1000; quota = 8'hC0;
      step();
      step();
      chk("mid_idx", 32'(gnt_idx), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
      chk("mid_rst_onehot", 32'(gnt_onehot), 32'd0);
      chk("mid_rst_idx", 32'(gnt_idx), 32'd0);
      step();
      rst = 1'b1;
      step();
      chk("post_rst_idx", 32'(gnt_idx), 32'd3);
      chk("post_rst_valid", 32'(gnt_valid), 32'd1);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
         if ($urandom_range(0, 7) == 0) quota = 8'($urandom);
         gnt_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
